// File: rtl/answer_sequencer.sv
// Majority-vote sequencer ahead of the light-output decode stage: collects a
// window of classifier codes, issues one registered decision, then holds off.
module answer_sequencer #(
  parameter int WINDOW      = 8,
  parameter int MIN_VOTES   = 5,
  parameter int HOLD_CYCLES = 1000,
  parameter int TIMEOUT     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sampleAnswer,
  input  logic       sampleValid,
  output logic       sampleReady,
  output logic [2:0] finalAnswer,
  output logic       finalDone,
  output logic       busy
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0] WINDOW_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] MIN_VOTES_C = CNT_W'(MIN_VOTES);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HOLD_LAST   = HLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                  state_r;
  logic [3:0][CNT_W-1:0]   vote_r;
  logic [CNT_W-1:0]        sample_cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic [HLD_W-1:0]        hold_cnt_r;
  logic                    stop_r;
  logic [2:0]              final_answer_r;
  logic                    final_done_r;
  logic                    busy_r;

  logic                    accept_s;
  logic                    is_stop_s;
  logic                    is_vote_s;
  logic [CNT_W-1:0]        sample_cnt_next_s;

  // A lone winner with enough votes is required; ties and weak maxima give NONE.
  function automatic logic [2:0] decide_code(input logic stop,
                                             input logic [3:0][CNT_W-1:0] votes);
    logic [CNT_W-1:0] best;
    logic [1:0]       best_idx;
    logic [2:0]       n_at_best;
    best      = '0;
    best_idx  = 2'd0;
    n_at_best = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (votes[i] > best) begin
        best     = votes[i];
        best_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (votes[i] == best) begin
        n_at_best = n_at_best + 3'd1;
      end
    end
    if (stop) begin
      decide_code = 3'd4;
    end else if ((best < MIN_VOTES_C) || (n_at_best != 3'd1)) begin
      decide_code = 3'd0;
    end else begin
      decide_code = {1'b0, best_idx};
    end
  endfunction

  assign sampleReady       = (state_r == ST_COLLECT);
  assign accept_s          = sampleValid & sampleReady;
  assign is_stop_s         = (sampleAnswer == 3'd4);
  assign is_vote_s         = ~sampleAnswer[2];
  assign sample_cnt_next_s = sample_cnt_r + CNT_W'(1);

  assign finalAnswer = final_answer_r;
  assign finalDone   = final_done_r;
  assign busy        = busy_r;

  // Sequencer state, window counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      vote_r         <= '0;
      sample_cnt_r   <= '0;
      tmo_cnt_r      <= '0;
      hold_cnt_r     <= '0;
      stop_r         <= 1'b0;
      final_answer_r <= 3'd0;
      final_done_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r      <= ST_COLLECT;
            busy_r       <= 1'b1;
            vote_r       <= '0;
            sample_cnt_r <= '0;
            tmo_cnt_r    <= '0;
            stop_r       <= 1'b0;
          end
        end
        ST_COLLECT: begin
          // Dropping enable abandons the window, even on a deciding edge.
          if (!enable) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            if (accept_s) begin
              sample_cnt_r <= sample_cnt_next_s;
              if (is_vote_s) begin
                vote_r[sampleAnswer[1:0]] <= vote_r[sampleAnswer[1:0]] + CNT_W'(1);
              end
            end
            if (accept_s && is_stop_s) begin
              stop_r  <= 1'b1;
              state_r <= ST_DECIDE;
            end else if ((accept_s && (sample_cnt_next_s == WINDOW_C)) ||
                         (tmo_cnt_r == TMO_LAST)) begin
              state_r <= ST_DECIDE;
            end
          end
        end
        ST_DECIDE: begin
          final_answer_r <= decide_code(stop_r, vote_r);
          final_done_r   <= 1'b1;
          hold_cnt_r     <= '0;
          state_r        <= ST_HOLD;
        end
        ST_HOLD: begin
          final_done_r <= 1'b0;
          if (hold_cnt_r == HOLD_LAST) begin
            if (enable) begin
              state_r      <= ST_COLLECT;
              vote_r       <= '0;
              sample_cnt_r <= '0;
              tmo_cnt_r    <= '0;
              stop_r       <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HLD_W'(1);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          final_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_answer_sequencer.sv
// Directed bench for answer_sequencer with a short hold and timeout.
module tb_answer_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] sampleAnswer;
  logic       sampleValid;
  logic       sampleReady;
  logic [2:0] finalAnswer;
  logic       finalDone;
  logic       busy;

  int errors = 0;
  int checks = 0;

  answer_sequencer #(
    .WINDOW(8), .MIN_VOTES(5), .HOLD_CYCLES(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sampleAnswer(sampleAnswer), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .finalAnswer(finalAnswer),
    .finalDone(finalDone), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Codes are listed first-sent in the most significant slot.
  task automatic send_seq(input logic [23:0] codes, input int n);
    for (int i = 0; i < n; i++) begin
      sampleValid  = 1'b1;
      sampleAnswer = codes[3*(n-1-i) +: 3];
      @(negedge clk);
    end
    sampleValid  = 1'b0;
    sampleAnswer = 3'd0;
  endtask

  // Called on the DECIDE cycle right after the deciding accept.
  task automatic decision(input string tag, input logic [2:0] exp_ans);
    check({tag, "_decide_ready"}, sampleReady, 1'b0);
    check({tag, "_decide_done"}, finalDone, 1'b0);
    @(negedge clk);
    check({tag, "_done"}, finalDone, 1'b1);
    check({tag, "_answer"}, finalAnswer, exp_ans);
    @(negedge clk);
    check({tag, "_done_drop"}, finalDone, 1'b0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!sampleReady && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, sampleReady, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_answer"}, finalAnswer, 3'd0);
    check({tag, "_done"}, finalDone, 1'b0);
    check({tag, "_ready"}, sampleReady, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sampleValid = 1'b0; sampleAnswer = 3'd0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");

    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("entry_ready", sampleReady, 1'b1);
    check("entry_busy", busy, 1'b1);

    // Majority of code 2: ready stays low through DECIDE plus four HOLD cycles.
    send_seq({3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2}, 8);
    decision("major2", 3'd2);
    for (int k = 0; k < 3; k++) begin
      check("major2_hold_ready", sampleReady, 1'b0);
      @(negedge clk);
    end
    check("major2_ready_back", sampleReady, 1'b1);

    send_seq({3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3}, 8);
    decision("tie", 3'd0);
    wait_ready("tie");

    // STOP on the third accept ends the window early.
    send_seq({15'd0, 3'd2, 3'd2, 3'd4}, 3);
    decision("stop", 3'd4);
    check("stop_hold_ready", sampleReady, 1'b0);
    wait_ready("stop");

    // enable falls alongside a valid sample: abandon without a decision.
    send_seq({15'd0, 3'd1, 3'd1, 3'd1}, 3);
    enable = 1'b0; sampleValid = 1'b1; sampleAnswer = 3'd1;
    @(negedge clk);
    sampleValid = 1'b0;
    check("drop_busy", busy, 1'b0);
    check("drop_ready", sampleReady, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("drop_no_done", finalDone, 1'b0);
      check("drop_answer_kept", finalAnswer, 3'd4);
      @(negedge clk);
    end

    // Re-enable with no samples: 20 COLLECT cycles then a forced NONE.
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("tmo_collect_ready", sampleReady, 1'b1);
      check("tmo_collect_done", finalDone, 1'b0);
      @(negedge clk);
    end
    decision("timeout", 3'd0);
    wait_ready("timeout");

    // Exactly MIN_VOTES for code 3; code 7 fills the window without voting.
    send_seq({3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd7}, 8);
    decision("min_votes", 3'd3);
    wait_ready("min_votes");

    send_seq({3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd6, 3'd6}, 8);
    decision("weak_max", 3'd0);
    wait_ready("weak_max");

    // Reset during HOLD.
    send_seq({3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2}, 8);
    decision("pre_rst_hold", 3'd2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_resume_ready", sampleReady, 1'b1);
    check("rst_hold_resume_busy", busy, 1'b1);

    // Reset during COLLECT.
    send_seq({3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, 8);
    decision("pre_rst_collect", 3'd1);
    wait_ready("pre_rst_collect");
    send_seq({15'd0, 3'd2, 3'd2, 3'd2}, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_collect");
    rst = 1'b0;
    @(negedge clk);
    check("rst_collect_resume_ready", sampleReady, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/answer_sequencer.md
Name: answer_sequencer

Overview:
- Controller ahead of the light-output decode stage.
- Collects a window of per-sample colour-pair classifications, majority-votes them, and issues one registered `finalAnswer` with a single-cycle `finalDone` strobe.
- After each decision it enforces a hold-off before the next one, so the light output cannot chatter.
- A STOP sample overrides the vote immediately.

Parameters:
- WINDOW, 8, number of accepted samples per decision (≥1).
- MIN_VOTES, 5, minimum votes the winning code needs (1..WINDOW).
- HOLD_CYCLES, 1000, clock cycles in HOLD after each decision (≥1).
- TIMEOUT, 100000, maximum cycles spent in COLLECT before a forced decision (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled every cycle.
- sampleAnswer  in  3  classifier code: NONE=0, R_B=1, R_G=2, B_G=3, STOP=4; codes 5..7 are invalid.
- sampleValid  in  1  sampleAnswer is valid this cycle.
- sampleReady  out  1  block accepts a sample this cycle.
- finalAnswer  out  3  decided code, registered; feeds the decode stage.
- finalDone  out  1  one-cycle strobe; finalAnswer is valid while it is high.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset:
  - state=IDLE; all vote counters, sample count, timeout count and hold count = 0.
  - finalAnswer=0 (NONE), finalDone=0, sampleReady=0, busy=0.
  - rst overrides everything, including mid-COLLECT and mid-HOLD; no finalDone is emitted.
- Accept: a sample is accepted on a rising edge when sampleValid & sampleReady.
- sampleReady is combinational from state: 1 only in COLLECT.
- IDLE:
  - If enable=1: go to COLLECT next cycle and clear all counters.
  - Otherwise stay in IDLE.
- COLLECT:
  - Per accepted sample: sample count += 1.
  - Code 0..3: the matching vote counter += 1.
  - Code 5..7: counts toward the window but casts no vote.
  - Code 4 (STOP): go to DECIDE with the STOP flag set. The window is discarded.
  - Sample count reaching WINDOW: go to DECIDE.
  - Timeout counter increments every COLLECT cycle. When it reaches TIMEOUT-1 with no other exit: go to DECIDE using the current counts, which may all be zero.
  - enable=0: go to IDLE. No finalDone; finalAnswer unchanged. enable=0 takes priority over any simultaneous accept or exit condition.
- DECIDE (exactly 1 cycle, sampleReady=0):
  - STOP flag set: result = 4.
  - Otherwise take the code 0..3 with the maximum count.
  - If that maximum < MIN_VOTES, or two or more codes tie at the maximum: result = 0 (NONE).
  - finalAnswer <= result; finalDone <= 1; go to HOLD.
- Latency:
  - Deciding sample accepted at edge k: DECIDE is active during cycle k+1.
  - finalDone=1 and the new finalAnswer are visible during cycle k+2, the first HOLD cycle.
- HOLD:
  - finalDone=0 after its first cycle.
  - The hold counter runs for HOLD_CYCLES cycles.
  - At expiry: go to COLLECT (counters cleared) if enable=1, else IDLE.
  - enable is ignored during the hold; inputs are ignored (sampleReady=0).
- finalAnswer holds its value between decisions and changes only in DECIDE or on rst.
- Counter widths:
  - Vote and sample counters: $clog2(WINDOW+1).
  - Timeout counter: $clog2(TIMEOUT+1).
  - Hold counter: $clog2(HOLD_CYCLES+1).
  - No counter wraps: each exits its state before overflow.
- sampleValid held high with sampleReady=0 loses no data on the block side; the producer must hold the sample.

Test Plan (WINDOW=8, MIN_VOTES=5, HOLD_CYCLES=4, TIMEOUT=20):
- 8 back-to-back samples, six of code 2 and two of code 1 → finalAnswer=2, finalDone high for exactly one cycle, 2 cycles after the 8th accept; sampleReady low for 5 cycles (DECIDE + 4 HOLD), then high again with enable=1.
- Codes 1,1,1,1,3,3,3,3 → tie gives finalAnswer=0. Separately, codes 1×4, 3×2, 6×2 → max 4 < 5 gives finalAnswer=0.
- Codes 2,2 then 4 on the 3rd accept → finalAnswer=4 two cycles after that accept; the remaining window is never collected.
- enable=1 with sampleValid=0 → finalDone with finalAnswer=0 after 20 COLLECT cycles + 1 DECIDE.
- enable dropped after 3 accepts → IDLE next cycle, busy=0, no finalDone, finalAnswer keeps its prior value.
- rst pulsed in HOLD and in COLLECT → the next cycle shows finalAnswer=0, finalDone=0, sampleReady=0, busy=0; with enable held high, COLLECT resumes one cycle after rst falls.
